// File: rtl/cgra_config_loader.sv
// Configuration fetch engine: reads a block of config words from config memory and streams them to the PE array over valid/ready.
// Optional build macro CGRA_CFG_LOADER_CSUM_EN adds a running XOR checksum output (csum) of delivered words.
module cgra_config_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   num_words,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH-1:0]            cfg_addr,
    output logic                             cfg_ren,
    input  logic [DATA_WIDTH-1:0]            cfg_rdata,
    input  logic                             cfg_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(MAX_WORDS)-1:0]     out_index
`ifdef CGRA_CFG_LOADER_CSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]            csum
`endif
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int IW = $clog2(MAX_WORDS);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         issued_q;
    logic [CW-1:0]         delivered_q;
    logic [IW-1:0]         recv_idx_q;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [IW-1:0]         fifo_idx  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic [CW-1:0]         sat_num;

    assign sat_num   = (num_words > MAX_CNT) ? MAX_CNT : num_words;
    assign accept    = (state == IDLE) && start;
    assign push      = cfg_valid && inflight;
    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_data[rd_ptr];
    assign out_index = fifo_idx[rd_ptr];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Words already buffered plus the one in flight must leave a free slot
    // after this cycle's pop, so a returning word always has somewhere to go.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign credit_ok = (occupancy <= (3'd1 + {2'b00, pop}));

    always_comb begin
        state_nxt = state;
        cfg_ren   = 1'b0;
        cfg_addr  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (sat_num == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if ((issued_q < count_q) && credit_ok) begin
                    cfg_ren  = 1'b1;
                    cfg_addr = base_q + (ADDR_WIDTH'(issued_q) << 3);
                    if ((issued_q + 1'b1) == count_q) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((delivered_q == count_q) ||
                    (pop && ((delivered_q + 1'b1) == count_q))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            recv_idx_q  <= '0;
            inflight    <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= cfg_ren;
            if (accept) begin
                base_q      <= base_addr & ~ADDR_WIDTH'(7);
                count_q     <= sat_num;
                issued_q    <= '0;
                delivered_q <= '0;
                recv_idx_q  <= '0;
            end else begin
                if (cfg_ren) begin
                    issued_q <= issued_q + 1'b1;
                end
                if (pop) begin
                    delivered_q <= delivered_q + 1'b1;
                end
                if (push) begin
                    recv_idx_q <= recv_idx_q + 1'b1;
                end
            end
        end
    end

    // Two-entry skid buffer; words return in issue order so the receive
    // counter doubles as the word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= cfg_rdata;
                fifo_idx[wr_ptr]  <= recv_idx_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef CGRA_CFG_LOADER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q ^ out_data;
        end
    end

    assign csum = csum_q;
`endif

endmodule
